// File: rtl/ula_pkg.sv
// Shared types and constants for the RPN ULA datapath blocks.
//   ULA_W       operand width
//   ULA_PW      product / accumulator width (2*ULA_W)
//   ula_state_e sequencer state for multi-cycle ULA operations
package ula_pkg;

  localparam int unsigned ULA_W  = 8;
  localparam int unsigned ULA_PW = 2 * ULA_W;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } ula_state_e;

endpackage

// File: rtl/ula_add16.sv
// Unsigned adder used for the accumulator update of the shift-add multiplier.
// The default width is 16 bits. The carry-out is dropped because the
// accumulator never exceeds Width bits.
//   a_i   [Width-1:0]  first operand
//   b_i   [Width-1:0]  second operand
//   sum_o [Width-1:0]  a_i + b_i (modulo 2^Width)
module ula_add16
  import ula_pkg::*;
#(
  parameter int unsigned Width = ULA_PW
) (
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  output logic [Width-1:0] sum_o
);

  assign sum_o = a_i + b_i;

endmodule

// File: rtl/ula_mult_acc_seq.sv
// Sequential shift-add multiplier-accumulator: P = Q*B + R (unsigned).
// This block is the MUL operation of the ULA. It also rebuilds a dividend
// from a quotient, divisor and remainder, so it can check DIV results.
// Every operation takes W iterations. No early exit is taken, so the
// latency is the same for all operands.
//   clk    rising-edge clock
//   rst    synchronous active-high reset
//   start  request, sampled only in idle
//   Q      multiplier (quotient)
//   B      multiplicand (divisor)
//   R      addend, zero-extended (remainder)
//   busy   high while iterating (exactly W cycles)
//   done   one-cycle pulse, P/ovf valid
//   P      result, held until the next result or rst
//   ovf    result needs more than W bits
// Optional macro ULA_MULACC_DIVCHECK_EN adds these ports:
//   A      original dividend, latched on accept
//   chk_ok high with done when P == A and R < B
module ula_mult_acc_seq
  import ula_pkg::*;
#(
  parameter int unsigned W = ULA_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   Q,
  input  logic [W-1:0]   B,
  input  logic [W-1:0]   R,
`ifdef ULA_MULACC_DIVCHECK_EN
  input  logic [W-1:0]   A,
  output logic           chk_ok,
`endif
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] P,
  output logic           ovf
);

  localparam int unsigned CntW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(W - 1);

  ula_state_e      state_q, state_d;
  logic [W-1:0]    mq_q, mq_d;
  logic [W-1:0]    mb_q, mb_d;
  logic [2*W-1:0]  acc_q, acc_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2*W-1:0]  p_q, p_d;
  logic            ovf_q, ovf_d;
  logic            done_q, done_d;
  logic [2*W-1:0]  addend;
  logic [2*W-1:0]  sum;

`ifdef ULA_MULACC_DIVCHECK_EN
  logic [W-1:0] a_q, a_d;
  logic [W-1:0] r_q, r_d;
  logic         chk_q, chk_d;
`endif

  // The partial product is shifted by the iteration count, so the
  // multiplicand register itself never shifts.
  assign addend = mq_q[0] ? ({{W{1'b0}}, mb_q} << cnt_q) : '0;

  ula_add16 #(
    .Width (2 * W)
  ) u_add (
    .a_i   (acc_q),
    .b_i   (addend),
    .sum_o (sum)
  );

  always_comb begin
    state_d = state_q;
    mq_d    = mq_q;
    mb_d    = mb_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
`ifdef ULA_MULACC_DIVCHECK_EN
    a_d     = a_q;
    r_d     = r_q;
    chk_d   = chk_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          mq_d    = Q;
          mb_d    = B;
          acc_d   = {{W{1'b0}}, R};
          cnt_d   = '0;
          state_d = StRun;
`ifdef ULA_MULACC_DIVCHECK_EN
          a_d     = A;
          r_d     = R;
`endif
        end
      end
      StRun: begin
        acc_d = sum;
        mq_d  = mq_q >> 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntLast) begin
          p_d     = sum;
          ovf_d   = |sum[2*W-1:W];
          done_d  = 1'b1;
          state_d = StDone;
`ifdef ULA_MULACC_DIVCHECK_EN
          chk_d   = (sum == {{W{1'b0}}, a_q}) && (r_q < mb_q);
`endif
        end
      end
      StDone: begin
        state_d = StIdle;
`ifdef ULA_MULACC_DIVCHECK_EN
        chk_d   = 1'b0;
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      mq_q    <= '0;
      mb_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      p_q     <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
`ifdef ULA_MULACC_DIVCHECK_EN
      a_q     <= '0;
      r_q     <= '0;
      chk_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      mq_q    <= mq_d;
      mb_q    <= mb_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
`ifdef ULA_MULACC_DIVCHECK_EN
      a_q     <= a_d;
      r_q     <= r_d;
      chk_q   <= chk_d;
`endif
    end
  end

  assign busy = (state_q == StRun);
  assign done = done_q;
  assign P    = p_q;
  assign ovf  = ovf_q;
`ifdef ULA_MULACC_DIVCHECK_EN
  assign chk_ok = chk_q;
`endif

endmodule

// File: tb/tb_ula_mult_acc_seq.sv
// Self-checking bench for ula_mult_acc_seq (W = 8). Each request pushes
// its expected result to a scoreboard queue. The test tasks pop that
// entry and compare it once done is seen.
module tb_ula_mult_acc_seq;

  typedef struct {
    logic [15:0] p;
    logic        ovf;
    logic        chk;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  q_s = '0, b_s = '0, r_s = '0, a_s = '0;
  logic        busy_s, done_s, ovf_s;
  logic [15:0] p_s;
  logic        chk_s;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  ula_mult_acc_seq #(
    .W (8)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .Q      (q_s),
    .B      (b_s),
    .R      (r_s),
`ifdef ULA_MULACC_DIVCHECK_EN
    .A      (a_s),
    .chk_ok (chk_s),
`endif
    .busy   (busy_s),
    .done   (done_s),
    .P      (p_s),
    .ovf    (ovf_s)
  );

`ifndef ULA_MULACC_DIVCHECK_EN
  assign chk_s = 1'b0;
`endif

  // Reference model: unsigned multiply-add plus the divide-check rule.
  task automatic push_exp(input logic [7:0] q, b, r, a);
    exp_t e;
    e.p   = 16'(q) * 16'(b) + 16'(r);
    e.ovf = |e.p[15:8];
    e.chk = (e.p == {8'h00, a}) && (r < b);
    sb.push_back(e);
  endtask

  // Issue one request, then scramble the operands after the accept edge.
  // Collect busy cycles, the done sample and whether done dropped again.
  task automatic do_op(input logic [7:0] q, b, r, a, output int busy_cyc,
                       output logic seen, output logic [15:0] p, output logic o,
                       output logic c, output logic one_cycle);
    @(posedge clk);
    #1 q_s = q; b_s = b; r_s = r; a_s = a; start = 1'b1;
    push_exp(q, b, r, a);
    @(posedge clk);
    #1 start = 1'b0;
    q_s = 8'($urandom); b_s = 8'($urandom); r_s = 8'($urandom); a_s = 8'($urandom);
    busy_cyc = 0; seen = 1'b0; p = '0; o = 1'b0; c = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (done_s) begin
        seen = 1'b1; p = p_s; o = ovf_s; c = chk_s;
      end else if (busy_s) begin
        busy_cyc++;
      end
    end
    @(negedge clk);
    one_cycle = seen && !done_s && !busy_s && (chk_s == 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (busy_s !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy_s); end
    n_checks++;
    if (done_s !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done_s); end
    n_checks++;
    if (p_s !== 16'h0000) begin n_fail++; $display("FAIL reset_p got %h want 0000", p_s); end
    n_checks++;
    if (ovf_s !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b want 0", ovf_s); end
    #1 rst = 1'b0;
  endtask

  task automatic test_ops(input string name, input logic [7:0] q, b, r, a);
    int busy_cyc; logic seen, o, c, one; logic [15:0] p; exp_t e;
    do_op(q, b, r, a, busy_cyc, seen, p, o, c, one);
    e = sb.pop_front();
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL %s_done_timeout got none want done", name); end
    n_checks++;
    if (busy_cyc !== 8) begin n_fail++; $display("FAIL %s_busy_cycles got %0d want 8", name, busy_cyc); end
    n_checks++;
    if (p !== e.p) begin n_fail++; $display("FAIL %s_p got %0d want %0d", name, p, e.p); end
    n_checks++;
    if (o !== e.ovf) begin n_fail++; $display("FAIL %s_ovf got %b want %b", name, o, e.ovf); end
    n_checks++;
    if (!one) begin n_fail++; $display("FAIL %s_done_pulse got stuck want one cycle", name); end
`ifdef ULA_MULACC_DIVCHECK_EN
    n_checks++;
    if (c !== e.chk) begin n_fail++; $display("FAIL %s_chk got %b want %b", name, c, e.chk); end
`endif
  endtask

  task automatic test_random();
    for (int k = 0; k < 4; k++) begin
      test_ops("rand", 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    end
  endtask

  // Start stays high with new operands during the run. The first result is
  // unaffected, and the held start is taken again at edge N+10.
  task automatic test_start_ignored();
    logic seen; exp_t e; int cyc;
    @(posedge clk);
    #1 q_s = 8'd12; b_s = 8'd10; r_s = 8'd3; a_s = 8'd0; start = 1'b1;
    push_exp(8'd12, 8'd10, 8'd3, 8'd0);
    @(posedge clk);                       // accept edge N
    #1 q_s = 8'd3; b_s = 8'd3; r_s = 8'd0;
    seen = 1'b0; cyc = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      cyc++;
      if (done_s) seen = 1'b1;
    end
    e = sb.pop_front();
    n_checks++;
    if (!seen || cyc != 9) begin n_fail++; $display("FAIL hold_latency got %0d want 9", cyc); end
    n_checks++;
    if (p_s !== e.p) begin n_fail++; $display("FAIL hold_p got %0d want %0d", p_s, e.p); end
    @(negedge clk);                       // after N+9: idle
    n_checks++;
    if (busy_s !== 1'b0) begin n_fail++; $display("FAIL hold_idle_busy got %b want 0", busy_s); end
    push_exp(8'd3, 8'd3, 8'd0, 8'd0);
    @(negedge clk);                       // after N+10: re-accepted
    n_checks++;
    if (busy_s !== 1'b1) begin n_fail++; $display("FAIL hold_reaccept got %b want 1", busy_s); end
    #1 start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (done_s) seen = 1'b1;
    end
    e = sb.pop_front();
    n_checks++;
    if (!seen || p_s !== e.p) begin
      n_fail++; $display("FAIL hold_second_p got %0d want %0d", p_s, e.p);
    end
  endtask

  // rst is sampled at the 4th run edge. The block must drop everything and
  // raise no done, then run a fresh operation normally.
  task automatic test_reset_abort();
    logic any_done;
    @(posedge clk);
    #1 q_s = 8'd200; b_s = 8'd100; r_s = 8'd1; start = 1'b1;
    @(posedge clk);                       // accept edge N
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);                       // edge N+4
    #1 rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy_s !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %b want 0", busy_s); end
    n_checks++;
    if (p_s !== 16'h0000) begin n_fail++; $display("FAIL abort_p got %h want 0000", p_s); end
    n_checks++;
    if (ovf_s !== 1'b0) begin n_fail++; $display("FAIL abort_ovf got %b want 0", ovf_s); end
    any_done = done_s;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      any_done = any_done | done_s | busy_s;
    end
    n_checks++;
    if (any_done !== 1'b0) begin n_fail++; $display("FAIL abort_no_done got %b want 0", any_done); end
    test_ops("after_abort", 8'd2, 8'd5, 8'd1, 8'd11);
  endtask

  initial begin
    test_reset();
    test_ops("basic", 8'd12, 8'd10, 8'd3, 8'd123);
    test_ops("max", 8'd255, 8'd255, 8'd255, 8'd0);
    test_ops("q_zero", 8'd0, 8'd200, 8'd7, 8'd7);
    test_ops("b_zero", 8'd77, 8'd0, 8'd9, 8'd9);
    test_random();
    test_start_ignored();
    test_reset_abort();
`ifdef ULA_MULACC_DIVCHECK_EN
    test_ops("chk_ok", 8'd12, 8'd10, 8'd3, 8'd123);
    test_ops("chk_r_ge_b", 8'd12, 8'd10, 8'd10, 8'd130);
    test_ops("chk_b_zero", 8'd5, 8'd0, 8'd3, 8'd3);
    test_ops("chk_bad_a", 8'd12, 8'd10, 8'd3, 8'd124);
`endif
    n_checks++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL scoreboard_left got %0d want 0", sb.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
